// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader.
package imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned MEM_BYTES_DEFAULT = 256;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_full flags the
// cycle in which the final byte of a word is accepted.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  byte_cnt;
    logic [31:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (accept) begin
            word_q[{byte_cnt, 3'b000} +: 8] <= byte_data;
            byte_cnt                        <= byte_cnt + 2'd1;
        end
    end

    assign word      = word_q;
    assign word_full = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory; holds the core while loading.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow_err,
    output logic              checksum_err
);

    state_t            state, state_nx;
    logic [7:0]        num_words_q;
    logic [7:0]        word_idx;
    logic              overflow_q;
    logic              start_ok;
    logic              load_accept;
    logic              last_word;
    logic [31:0]       word;
    logic              word_full;
    logic [ADDR_W-1:0] word_addr;
    logic              addr_ovf;

    assign start_ok    = start && (state == ST_IDLE || state == ST_DONE);
    assign load_accept = (state == ST_LOAD) && byte_valid;
    assign last_word   = (word_idx == num_words_q - 8'd1);
    assign word_addr   = BASE_ADDR + ADDR_W'({word_idx, 2'b00});
    assign addr_ovf    = (word_addr + ADDR_W'(BYTES_PER_WORD - 1)) >= ADDR_W'(MEM_BYTES);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .accept    (load_accept),
        .byte_data (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nx = (num_words == 8'd0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                if (word_full) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                if (addr_ovf) begin
                    state_nx = ST_DONE;
                end else if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = ST_CHECK;
`else
                    state_nx = ST_DONE;
`endif
                end else begin
                    state_nx = ST_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_valid) state_nx = ST_DONE;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == ST_LOAD) || (state == ST_CHECK);
        wr_en      = (state == ST_WRITE) && !addr_ovf;
        wr_addr    = wr_en ? word_addr : '0;
        wr_data    = wr_en ? word : '0;
        cpu_hold   = (state == ST_LOAD) || (state == ST_WRITE) || (state == ST_CHECK);
        done       = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_words_q <= '0;
            word_idx    <= '0;
            overflow_q  <= 1'b0;
        end else if (start_ok) begin
            num_words_q <= num_words;
            word_idx    <= '0;
            overflow_q  <= 1'b0;
        end else if (state == ST_WRITE) begin
            if (addr_ovf) begin
                overflow_q <= 1'b1;
            end else if (!last_word) begin
                word_idx <= word_idx + 8'd1;
            end
        end
    end

    assign overflow_err = overflow_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       cksum_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cksum_err_q <= 1'b0;
        end else if (start_ok) begin
            sum_q       <= '0;
            cksum_err_q <= 1'b0;
        end else if (load_accept) begin
            sum_q <= sum_q + byte_data;
        end else if (state == ST_CHECK && byte_valid && byte_data != sum_q) begin
            cksum_err_q <= 1'b1;
        end
    end

    assign checksum_err = cksum_err_q;
`else
    assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and popped by per-instance monitors whenever wr_en is seen.
module tb_imem_loader;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  num_words = '0;
    logic [7:0]  byte_data = '0;
    logic [7:0]  sum_acc = '0;

    logic        br0, we0, ch0, dn0, oe0, ce0;
    logic [63:0] wa0;
    logic [31:0] wd0;
    logic        br1, we1, ch1, dn1, oe1, ce1;
    logic [63:0] wa1;
    logic [31:0] wd1;

    wr_t q0[$];
    wr_t q1[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(64), .MEM_BYTES(256), .BASE_ADDR(64'd0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .num_words(num_words),
        .byte_valid(byte_valid & ~sel), .byte_data(byte_data), .byte_ready(br0),
        .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .cpu_hold(ch0), .done(dn0),
        .overflow_err(oe0), .checksum_err(ce0)
    );

    imem_loader #(.ADDR_W(64), .MEM_BYTES(256), .BASE_ADDR(64'd252)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .num_words(num_words),
        .byte_valid(byte_valid & sel), .byte_data(byte_data), .byte_ready(br1),
        .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .cpu_hold(ch1), .done(dn1),
        .overflow_err(oe1), .checksum_err(ce1)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (we0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write0: addr %0h data %0h", wa0, wd0);
            end else begin
                e = q0.pop_front();
                check("wr_addr0", wa0, e.addr);
                check("wr_data0", {32'd0, wd0}, {32'd0, e.data});
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (we1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write1: addr %0h data %0h", wa1, wd1);
            end else begin
                e = q1.pop_front();
                check("wr_addr1", wa1, e.addr);
                check("wr_data1", {32'd0, wd1}, {32'd0, e.data});
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        num_words = n;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        sum_acc   = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        acc        = 1'b0;
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = sel ? br1 : br0;
            cycle();
        end
        byte_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte %0h not taken within 50 cycles", b);
        end
        sum_acc = sum_acc + b;
        if (gap) cycle();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
    endtask

    task automatic end_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(sum_acc, 1'b0);
`endif
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? dn1 : dn0;
        end
        check(name, {63'd0, ok}, 64'd1);
        cycle();
    endtask

    initial begin
        logic [31:0] w;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {58'd0, we0, ch0, dn0, oe0, ce0, br0}, 64'd0);
        check("reset_addr", wa0, 64'd0);
        check("reset_data", {32'd0, wd0}, 64'd0);
        rst_n = 1'b1;
        cycle();

        // 1: single word
        q0.push_back('{64'd0, 32'h00002083});
        do_start(8'd1);
        check("t1_cpu_hold", {63'd0, ch0}, 64'd1);
        send_byte(8'h83, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        end_load();
        wait_done("t1_done");
        check("t1_idle_flags", {60'd0, ch0, oe0, ce0, br0}, 64'd0);

        // 2: nine words, byte_valid toggling
        for (int j = 0; j < 9; j++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(((4 * j + k) * 13) + 5);
            q0.push_back('{64'(4 * j), w});
        end
        do_start(8'd9);
        for (int i = 0; i < 36; i++) send_byte(8'((i * 13) + 5), 1'b1);
        end_load();
        wait_done("t2_done");
        check("t2_all_written", 64'(q0.size()), 64'd0);

        // 4: reset after two bytes of the second word
        q0.push_back('{64'd0, 32'h11223344});
        do_start(8'd2);
        send_word(32'h11223344);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        cycle();
        rst_n = 1'b0;
        #1;
        check("t4_reset_ctrl", {58'd0, we0, ch0, dn0, oe0, ce0, br0}, 64'd0);
        check("t4_reset_addr", wa0, 64'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        q0.push_back('{64'd0, 32'hCAFEBABE});
        do_start(8'd1);
        send_word(32'hCAFEBABE);
        end_load();
        wait_done("t4_reload_done");
        check("t4_written", 64'(q0.size()), 64'd0);

        // 5: mid-load start ignored, then zero-length load
        q0.push_back('{64'd0, 32'hA1B2C3D4});
        q0.push_back('{64'd4, 32'h0F1E2D3C});
        do_start(8'd2);
        send_byte(8'hD4, 1'b0);
        send_byte(8'hC3, 1'b0);
        num_words = 8'd5;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        check("t5_hold_mid", {62'd0, ch0, dn0}, 64'd2);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_word(32'h0F1E2D3C);
        end_load();
        wait_done("t5_done");
        check("t5_written", 64'(q0.size()), 64'd0);
        do_start(8'd0);
        check("t5_zero_len", {61'd0, dn0, ch0, oe0}, 64'd4);
        repeat (3) cycle();
        check("t5_zero_stays", {62'd0, dn0, ch0}, 64'd2);

        // 3: overflow at the top of memory
        sel = 1'b1;
        q1.push_back('{64'd252, 32'hDEADBEEF});
        do_start(8'd2);
        send_word(32'hDEADBEEF);
        send_word(32'h01020304);
        wait_done("t3_done");
        check("t3_overflow", {63'd0, oe1}, 64'd1);
        check("t3_written", 64'(q1.size()), 64'd0);
        do_start(8'd0);
        check("t3_err_cleared", {63'd0, oe1}, 64'd0);
        sel = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: trailing checksum byte
        q0.push_back('{64'd0, 32'h00002083});
        do_start(8'd1);
        send_word(32'h00002083);
        send_byte(8'hA3, 1'b0);
        wait_done("t6_good_done");
        check("t6_good_sum", {63'd0, ce0}, 64'd0);
        q0.push_back('{64'd0, 32'h00002083});
        do_start(8'd1);
        send_word(32'h00002083);
        send_byte(8'hA4, 1'b0);
        wait_done("t6_bad_done");
        check("t6_bad_sum", {63'd0, ce0}, 64'd1);
        do_start(8'd0);
        check("t6_err_cleared", {63'd0, ce0}, 64'd0);
`else
        check("checksum_off", {63'd0, ce0}, 64'd0);
`endif

        repeat (2) cycle();
        check("queues_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
